// File: rtl/spi_controller.sv
// Write-only SPI mode-0 controller: shifts {1'b1, addr, data} MSB first, 35*CLK_DIV+1 cycles start-to-done.
// No backpressure: start is honoured only when idle, requests while busy are dropped.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] sh_q, sh_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        copi_q, copi_d;

    logic        div_end;

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        copi_d  = copi_q;

        unique case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (start) begin
                    sh_d    = {1'b1, addr, data};
                    copi_d  = 1'b1;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            SHIFT: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    bit_d  = bit_q + 5'd1;
                    // Data advances only on the falling sclk edge so it is stable around each rising edge.
                    if (sclk_q) begin
                        sh_d   = {sh_q[14:0], 1'b0};
                        copi_d = sh_q[14];
                    end
                    if (bit_q == 5'd31) begin
                        state_d = HOLD;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            HOLD: begin
                if (div_end) begin
                    div_d   = '0;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            GAP: begin
                if (div_end) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                ncs_d   = 1'b1;
                copi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sclk = sclk_q;
    assign ncs  = ncs_q;
    assign copi = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: table of frames plus ignored-start, mid-frame reset and back-to-back sequences.
module tb_spi_controller;

    localparam int CLK_DIV  = 4;
    localparam int DONE_CYC = 35 * CLK_DIV + 1;
    localparam int NCS_LOW  = 34 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] addr;
    logic [7:0] data;
    logic       busy, done, sclk, ncs, copi;

    spi_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .addr  (addr),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .sclk  (sclk),
        .ncs   (ncs),
        .copi  (copi)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Peripheral-side model: samples copi on sclk rising edges, commits on ncs rising.
    logic        mon_en = 1'b0;
    logic [15:0] rx = '0;
    int          rx_bits = 0;
    logic [15:0] last_frame = '0;
    int          frame_cnt = 0;
    int          partial_cnt = 0;
    int          bad_sclk = 0;
    int          done_cnt = 0;
    longint      rise_t = 0;
    longint      fall_t = 0;
    logic [7:0]  regs [0:127];

    always @(posedge sclk) begin
        if (mon_en && rst_n) begin
            rx      = {rx[14:0], copi};
            rx_bits = rx_bits + 1;
        end
    end

    always @(posedge ncs) begin
        rise_t = $time;
        if (mon_en) begin
            if (rx_bits == 16) begin
                last_frame = rx;
                frame_cnt  = frame_cnt + 1;
                if (rx[15]) regs[rx[14:8]] = rx[7:0];
            end else if (rx_bits != 0) begin
                partial_cnt = partial_cnt + 1;
            end
            rx_bits = 0;
        end
    end

    always @(negedge ncs) fall_t = $time;

    always @(sclk) begin
        if (mon_en && rst_n && ncs === 1'b1) bad_sclk = bad_sclk + 1;
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Presents a request; returns just after the edge that samples it.
    task automatic send(input logic [6:0] a, input logic [7:0] d);
        addr  = a;
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // kind 0: plain, 1: extra start at cycle inj, 2: reset at cycle inj, 3: back-to-back start on done.
    task automatic track(input int kind, input int inj, output int cyc, output int nlow, output bit ok);
        cyc  = 0;
        nlow = 0;
        ok   = 1'b0;
        while (cyc < 2000) begin
            cyc = cyc + 1;
            if (!ncs) nlow = nlow + 1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (kind == 1 && cyc == inj) begin
                start = 1'b1;
                addr  = 7'h7F;
                data  = 8'h00;
            end
            if (kind == 1 && cyc == inj + 1) start = 1'b0;
            if (kind == 2 && cyc == inj) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_mid_ncs", ncs, 1'b1);
                chk("rst_mid_sclk", sclk, 1'b0);
                chk("rst_mid_busy", busy, 1'b0);
                chk("rst_mid_copi", copi, 1'b0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (kind == 3 && ok) begin
            start = 1'b1;
            addr  = 7'h01;
            data  = 8'h3C;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] f;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int  cyc, nlow, fc0, dc0, bs0, gap;
        bit  ok;

        tbl[0] = '{a: 7'h04, d: 8'h80, f: 16'h8480};
        tbl[1] = '{a: 7'h7F, d: 8'h00, f: 16'hFF00};
        tbl[2] = '{a: 7'h01, d: 8'h3C, f: 16'h813C};
        tbl[3] = '{a: 7'h00, d: 8'hFF, f: 16'h80FF};
        tbl[4] = '{a: 7'h04, d: 8'hA5, f: 16'h84A5};
        tbl[5] = '{a: 7'h2A, d: 8'hC3, f: 16'hAAC3};
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;

        rst_n = 1'b0;
        start = 1'b0;
        addr  = '0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ncs", ncs, 1'b1);
        chk("reset_sclk", sclk, 1'b0);
        chk("reset_copi", copi, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            fc0 = frame_cnt;
            bs0 = bad_sclk;
            send(tbl[i].a, tbl[i].d);
            chk($sformatf("v%0d_busy_set", i), busy, 1'b1);
            chk($sformatf("v%0d_ncs_low", i), ncs, 1'b0);
            track(0, 0, cyc, nlow, ok);
            chk($sformatf("v%0d_done_cycle", i), cyc, DONE_CYC);
            chk($sformatf("v%0d_ncs_low_cycles", i), nlow, NCS_LOW);
            chk($sformatf("v%0d_frame_count", i), frame_cnt - fc0, 1);
            chk($sformatf("v%0d_frame", i), last_frame, tbl[i].f);
            chk($sformatf("v%0d_busy_on_done", i), busy, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_width", i), done, 1'b0);
            chk($sformatf("v%0d_sclk_while_ncs_high", i), bad_sclk - bs0, 0);
            repeat (3) @(posedge clk);
            #1;
        end
        chk("periph_duty_reg", regs[4], 8'hA5);
        chk("periph_oe_reg", regs[0], 8'hFF);

        // Second start mid-frame with different addr/data must not disturb the frame in flight.
        fc0 = frame_cnt;
        dc0 = done_cnt;
        send(7'h00, 8'h11);
        track(1, 50, cyc, nlow, ok);
        chk("ign_done_cycle", cyc, DONE_CYC);
        repeat (200) @(posedge clk);
        #1;
        chk("ign_frame", last_frame, 16'h8011);
        chk("ign_frame_count", frame_cnt - fc0, 1);
        chk("ign_done_count", done_cnt - dc0, 1);
        chk("ign_busy_idle", busy, 1'b0);

        // Reset at cycle 60 aborts silently; the next request goes out whole.
        fc0 = frame_cnt;
        dc0 = done_cnt;
        send(7'h33, 8'h33);
        track(2, 60, cyc, nlow, ok);
        repeat (200) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - dc0, 0);
        chk("rst_no_frame", frame_cnt - fc0, 0);
        chk("rst_busy_idle", busy, 1'b0);
        send(7'h02, 8'h55);
        track(0, 0, cyc, nlow, ok);
        chk("rst_next_done_cycle", cyc, DONE_CYC);
        chk("rst_next_frame", last_frame, 16'h8255);
        chk("rst_next_frame_count", frame_cnt - fc0, 1);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back: start on the done cycle launches the next frame immediately.
        fc0 = frame_cnt;
        send(7'h00, 8'hFF);
        track(3, 0, cyc, nlow, ok);
        chk("b2b_first_done", cyc, DONE_CYC);
        chk("b2b_first_frame", last_frame, 16'h80FF);
        chk("b2b_second_busy", busy, 1'b1);
        gap = int'((fall_t - rise_t) / 10);
        chk("b2b_ncs_gap_ge_div", (gap >= CLK_DIV), 1'b1);
        track(0, 0, cyc, nlow, ok);
        chk("b2b_second_done", cyc, DONE_CYC);
        chk("b2b_second_frame", last_frame, 16'h813C);
        chk("b2b_frame_count", frame_cnt - fc0, 2);
        chk("total_sclk_while_ncs_high", bad_sclk, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
